// File: rtl/legv8_instr_encoder.sv
// Program loader: accepts LEGv8 instruction descriptors over a valid/ready
// handshake, encodes them and writes one machine word per cycle into imem.
module legv8_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [18:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    typedef enum logic [2:0] {
        CLS_ADD = 3'd0, CLS_SUB = 3'd1, CLS_AND = 3'd2, CLS_ORR = 3'd3,
        CLS_LDUR = 3'd4, CLS_STUR = 3'd5, CLS_CBZ = 3'd6, CLS_RSVD = 3'd7
    } op_class_e;

    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;

    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, idx_q, addr_q;
    logic [ADDR_W:0]   cnt_q, loaded_q;
    logic [31:0]       wdata_q;
    logic              we_q, err_q;
    logic              accept, start_ok;

    // Reserved class returns 0; the caller suppresses the write for it.
    function automatic logic [31:0] encode(input logic [2:0] cls, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [18:0] imm);
        case (op_class_e'(cls))
            CLS_ADD:  encode = {OP_ADD,  rm, 6'b0, rn, rd};
            CLS_SUB:  encode = {OP_SUB,  rm, 6'b0, rn, rd};
            CLS_AND:  encode = {OP_AND,  rm, 6'b0, rn, rd};
            CLS_ORR:  encode = {OP_ORR,  rm, 6'b0, rn, rd};
            CLS_LDUR: encode = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
            CLS_STUR: encode = {OP_STUR, imm[8:0], 2'b00, rn, rd};
            CLS_CBZ:  encode = {OP_CBZ,  imm, rd};
            default:  encode = 32'h0;
        endcase
    endfunction

    assign accept   = in_valid && (state_q == LOAD);
    assign start_ok = start && (state_q != LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (length == '0) ? DONE : LOAD;
            LOAD:       if (accept && cnt_q == CNT_ONE) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (start_ok) begin
                base_q   <= base_addr;
                cnt_q    <= length;
                idx_q    <= '0;
                loaded_q <= '0;
                err_q    <= 1'b0;
            end else if (accept) begin
                cnt_q <= cnt_q - CNT_ONE;
                if (in_class == CLS_RSVD) begin
                    err_q <= 1'b1;
                end else begin
                    we_q     <= 1'b1;
                    addr_q   <= base_q + idx_q;
                    wdata_q  <= encode(in_class, in_rd, in_rn, in_rm, in_imm);
                    idx_q    <= idx_q + IDX_ONE;
                    loaded_q <= loaded_q + CNT_ONE;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign loaded     = loaded_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench for legv8_instr_encoder: hand-encoded LEGv8 words checked at
// each falling edge; inputs are driven on falling edges too.
module tb_legv8_instr_encoder;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd, in_rn, in_rm;
    logic [18:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;
    logic [ADDR_W:0]   loaded;

    int n_tests = 0;
    int n_fail  = 0;

    legv8_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic desc(input logic v, input logic [2:0] c, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [18:0] imm);
        in_valid = v; in_class = c; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    endtask

    task automatic go(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] len);
        start = 1'b1; base_addr = b; length = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        #2;
        check("rst_we", imem_we, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy_done_err", {busy, done, err}, 0);
        check("rst_loaded", loaded, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // T1: single ADD
        go(6'd0, 7'd1);
        check("t1_busy", busy, 1);
        check("t1_ready", in_ready, 1);
        desc(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 19'd0);
        @(negedge clk);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("t1_we", imem_we, 1);
        check("t1_addr", imem_addr, 0);
        check("t1_wdata", imem_wdata, 32'h8B020023);
        check("t1_done", done, 1);
        check("t1_loaded", loaded, 1);
        check("t1_ready_off", in_ready, 0);
        @(negedge clk);
        check("t1_we_once", imem_we, 0);
        check("t1_wdata_hold", imem_wdata, 32'h8B020023);

        // T2: LDUR then STUR back-to-back
        go(6'd5, 7'd2);
        desc(1'b1, 3'd4, 5'd9, 5'd22, 5'd0, 19'd64);
        @(negedge clk);
        check("t2_we0", imem_we, 1);
        check("t2_addr0", imem_addr, 5);
        check("t2_wdata0", imem_wdata, 32'hF84402C9);
        check("t2_busy_mid", busy, 1);
        desc(1'b1, 3'd5, 5'd5, 5'd0, 5'd0, 19'd8);
        @(negedge clk);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("t2_we1", imem_we, 1);
        check("t2_addr1", imem_addr, 6);
        check("t2_wdata1", imem_wdata, 32'hF8008005);
        check("t2_done", done, 1);
        check("t2_loaded", loaded, 2);

        // T3: CBZ after a 3-cycle valid gap; a start in LOAD is ignored
        go(6'd10, 7'd1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin start = 1'b1; base_addr = 6'd40; length = 7'd0; end
            else start = 1'b0;
            @(negedge clk);
            check("t3_gap_we", imem_we, 0);
            check("t3_gap_busy", busy, 1);
        end
        start = 1'b0;
        desc(1'b1, 3'd6, 5'd1, 5'd7, 5'd9, 19'd3);
        @(negedge clk);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("t3_we", imem_we, 1);
        check("t3_addr", imem_addr, 10);
        check("t3_wdata", imem_wdata, 32'hB4000061);
        check("t3_done", done, 1);

        // T4: address wrap from 63 to 0
        go(6'd63, 7'd2);
        desc(1'b1, 3'd1, 5'd1, 5'd1, 5'd1, 19'd0);
        @(negedge clk);
        check("t4_addr0", imem_addr, 63);
        check("t4_wdata0", imem_wdata, 32'hCB010021);
        @(negedge clk);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("t4_we1", imem_we, 1);
        check("t4_addr1", imem_addr, 0);
        check("t4_wdata1", imem_wdata, 32'hCB010021);

        // T5: ORR, reserved, AND
        go(6'd20, 7'd3);
        desc(1'b1, 3'd3, 5'd2, 5'd3, 5'd4, 19'd0);
        @(negedge clk);
        check("t5_addr0", imem_addr, 20);
        check("t5_wdata0", imem_wdata, 32'hAA040062);
        desc(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 19'd0);
        @(negedge clk);
        check("t5_rsvd_we", imem_we, 0);
        check("t5_rsvd_err", err, 1);
        check("t5_rsvd_loaded", loaded, 1);
        check("t5_rsvd_busy", busy, 1);
        desc(1'b1, 3'd2, 5'd5, 5'd6, 5'd7, 19'd0);
        @(negedge clk);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        check("t5_we1", imem_we, 1);
        check("t5_addr1", imem_addr, 21);
        check("t5_wdata1", imem_wdata, 32'h8A0700C5);
        check("t5_done", done, 1);
        check("t5_err_hold", err, 1);
        check("t5_loaded", loaded, 2);
        go(6'd30, 7'd1);
        check("t5_err_clr", err, 0);
        check("t5_loaded_clr", loaded, 0);

        // T6: reset one cycle after an accept drops the pending write
        desc(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 19'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_we", imem_we, 0);
        check("t6_wdata", imem_wdata, 0);
        check("t6_flags", {in_ready, busy, done, err}, 0);
        check("t6_loaded", loaded, 0);
        desc(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        @(negedge clk);
        check("t6_we_held", imem_we, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_we_after", imem_we, 0);
        go(6'd0, 7'd0);
        check("t6_len0_done", done, 1);
        check("t6_len0_busy", busy, 0);
        check("t6_len0_we", imem_we, 0);
        check("t6_len0_loaded", loaded, 0);
        @(negedge clk);
        check("t6_len0_we2", imem_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
